// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: FSM states, default timing and bus mode.
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        GAP,
        CS_HOLD,
        CS_OFF
    } state_t;

    localparam int unsigned DEFAULT_CLK_DIV       = 2;
    localparam int unsigned DEFAULT_CS_OFF_CYCLES = 4;

    // CPOL=0, CPHA=0
    localparam logic [1:0] SPI_MODE = 2'd0;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: toggles SCK every CLK_DIV enabled cycles and flags the cycle
// in which the SCK flop is about to rise or fall.
module spi_sck_gen
    import spi_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;
    logic       phase_end;

    assign phase_end = enable && (cnt == PHASE_LAST);
    assign rise      = phase_end && !sck;
    assign fall      = phase_end && sck;

    // Disabling forces SCK low and restarts the phase count for the next byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
            sck <= 1'b0;
        end else if (!enable) begin
            cnt <= 8'd0;
            sck <= 1'b0;
        end else if (phase_end) begin
            cnt <= 8'd0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: byte-wide TX/RX handshake, frames delimited by a last flag,
// with CS hold and minimum CS-off spacing between frames.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned CLK_DIV       = DEFAULT_CLK_DIV,
    parameter int unsigned CS_OFF_CYCLES = DEFAULT_CS_OFF_CYCLES
) (
    input  logic       clock50_i,
    input  logic       reset_n_i,
    input  logic       TX_valid_i,
    input  logic [7:0] TX_data_i,
    input  logic       TX_last_i,
    output logic       TX_ready_o,
    output logic       RX_valid_o,
    output logic [7:0] RX_data_o,
    output logic       busy_o,
    output logic       SPI_clock_o,
    output logic       SPI_mosi_o,
    output logic       SPI_cs_n_o,
    input  logic       SPI_miso_i
);

    localparam logic [7:0] HOLD_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] OFF_LAST  = 8'(CS_OFF_CYCLES - 1);

    state_t     state, next_state;
    logic [7:0] tx_shift, rx_shift, rx_data, wait_cnt;
    logic [2:0] bit_cnt;
    logic       last_flag, ready, cs_n, mosi, rx_valid;
    logic       sck_rise, sck_fall, accept, byte_done;

    assign accept    = TX_valid_i && ready;
    assign byte_done = sck_fall && (bit_cnt == 3'd7);

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk    (clock50_i),
        .rst_n  (reset_n_i),
        .enable (state == SHIFT),
        .sck    (SPI_clock_o),
        .rise   (sck_rise),
        .fall   (sck_fall)
    );

    always_ff @(posedge clock50_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SHIFT;
            SHIFT:   if (byte_done) next_state = last_flag ? CS_HOLD : GAP;
            GAP:     if (accept) next_state = SHIFT;
            CS_HOLD: if (wait_cnt == HOLD_LAST) next_state = CS_OFF;
            CS_OFF:  if (wait_cnt == OFF_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake and CS are registered from next_state so every SPI pin comes from a flop
    always_ff @(posedge clock50_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ready     <= 1'b0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= 8'd0;
            rx_shift  <= 8'd0;
            tx_shift  <= 8'd0;
            last_flag <= 1'b0;
            bit_cnt   <= 3'd0;
            wait_cnt  <= 8'd0;
        end else begin
            ready    <= (next_state == IDLE) || (next_state == GAP);
            cs_n     <= (next_state == IDLE) || (next_state == CS_OFF);
            rx_valid <= byte_done;
            wait_cnt <= ((next_state == state) && (state == CS_HOLD || state == CS_OFF))
                        ? wait_cnt + 8'd1 : 8'd0;
            if (accept) begin
                tx_shift  <= TX_data_i;
                mosi      <= TX_data_i[7];
                last_flag <= TX_last_i;
                bit_cnt   <= 3'd0;
            end else if (sck_fall) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (!byte_done) begin
                    mosi     <= tx_shift[6];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end else if (next_state == IDLE) begin
                mosi <= 1'b0;
            end
            if (sck_rise) rx_shift <= {rx_shift[6:0], SPI_miso_i};
            if (byte_done) rx_data <= rx_shift;
        end
    end

    assign TX_ready_o = ready;
    assign RX_valid_o = rx_valid;
    assign RX_data_o  = rx_data;
    assign busy_o     = (state != IDLE);
    assign SPI_cs_n_o = cs_n;
    assign SPI_mosi_o = mosi;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The module SHALL take parameter CLK_DIV, default 2, giving SCK half-period in clock50_i cycles (legal range 1..255).
REQ-002 The module SHALL take parameter CS_OFF_CYCLES, default 4, giving minimum CS_n deasserted time in clock50_i cycles (legal range 1..255).
REQ-003 The module SHALL have one clock; reset is asynchronous and active-low, on ports clock50_i and reset_n_i.
REQ-004 clock50_i  in  1  system clock; all logic on its rising edge.
REQ-005 reset_n_i  in  1  asynchronous active-low reset.
REQ-006 TX_valid_i  in  1  byte offered for transmission.
REQ-007 TX_data_i  in  8  byte to send, MSB first.
REQ-008 TX_last_i  in  1  offered byte ends the frame; CS_n releases after it.
REQ-009 TX_ready_o  out  1  module accepts a byte this cycle.
REQ-010 RX_valid_o  out  1  one-cycle pulse; RX_data_o holds a new byte.
REQ-011 RX_data_o  out  8  byte received on MISO; held until the next pulse.
REQ-012 busy_o  out  1  high whenever state is not IDLE.
REQ-013 SPI_clock_o, SPI_mosi_o, SPI_cs_n_o  out  1 each; SPI_miso_i  in  1.

Function
REQ-014 Protocol SHALL be SPI mode 0: SCK idles low; MOSI changes on SCK falling edge or on frame start; MISO is sampled at SCK rising edge.
REQ-015 The FSM SHALL have states IDLE, SHIFT, GAP, CS_HOLD and CS_OFF.
REQ-016 A transfer SHALL be accepted on a cycle with TX_valid_i & TX_ready_o. TX_ready_o SHALL be high only in IDLE and GAP.
REQ-017 On acceptance in IDLE, the next cycle SHALL have CS_n=0, MOSI=TX_data_i[7], state SHIFT, and the low phase started.
REQ-018 In SHIFT, each bit SHALL be CLK_DIV cycles with SCK low, then CLK_DIV cycles with SCK high. One byte SHALL take exactly 16*CLK_DIV cycles.
REQ-019 MISO SHALL be registered in the cycle in which SPI_clock_o is driven 0->1. The shift-in SHALL be MSB first.
REQ-020 MOSI SHALL advance to the next bit in the same cycle SCK is driven 1->0, for bits 6..0 only.
REQ-021 After the 8th high phase, SCK SHALL return low and RX_valid_o SHALL pulse in that cycle with the complete byte. RX_valid_o therefore pulses 16*CLK_DIV+1 cycles after the accepting edge.
REQ-022 If the latched last flag is 0, the next state SHALL be GAP. GAP holds CS_n=0, SCK=0 and MOSI at its last value, for an unbounded time.
REQ-023 Acceptance in GAP SHALL enter SHIFT next cycle with MOSI=new bit 7, identical to REQ-017 except CS_n is already low.
REQ-024 If the latched last flag is 1, the FSM SHALL go to CS_HOLD for CLK_DIV cycles (SCK low, CS_n low), then drive CS_n=1 and enter CS_OFF.
REQ-025 CS_OFF SHALL last CS_OFF_CYCLES cycles with TX_ready_o low, then go to IDLE.
REQ-026 TX_data_i and TX_last_i SHALL be latched at acceptance. Later changes on TX_data_i or TX_last_i SHALL NOT affect the byte in flight.
REQ-027 TX_valid_i held high with no acceptance (e.g. in SHIFT) SHALL be ignored until TX_ready_o rises. There is no implicit queueing.
REQ-028 MOSI SHALL be 0 in IDLE. SCK SHALL never glitch, and each SCK phase SHALL be exactly CLK_DIV cycles.
REQ-029 All SPI outputs SHALL come directly from flops.

Reset
REQ-030 While reset_n_i=0: state=IDLE, SPI_cs_n_o=1, SPI_clock_o=0, SPI_mosi_o=0, RX_valid_o=0, RX_data_o=8'h00, TX_ready_o=0, busy_o=0. All counters and shift registers SHALL be zero.
REQ-031 Reset asserted mid-byte SHALL abort the transfer immediately, with no RX_valid_o pulse. CS_n SHALL rise asynchronously.
REQ-032 TX_ready_o SHALL go high the first cycle after reset release.

Structure
REQ-033 A shared package SHALL hold the FSM state enumeration and the default CLK_DIV and CS_OFF_CYCLES values. The same package SHALL hold the SPI mode constant.
REQ-034 One sub-module, spi_sck_gen, SHALL produce SCK and the one-cycle rise/fall strobes from CLK_DIV; it is enabled only in SHIFT.

Verification
REQ-035 Single byte: CLK_DIV=2, send 8'hA5 last=1, slave returns 8'h3C -> MOSI bits 1,0,1,0,0,1,0,1 and 8 SCK pulses of 4 cycles each. RX_valid_o SHALL pulse at acceptance+33 with RX_data_o=8'h3C, and CS_n SHALL rise 2 cycles later.
REQ-036 Two-byte frame: 8'h80 last=0, then 8'h01 last=1 presented in GAP -> CS_n SHALL stay low throughout, with 16 SCK pulses and two RX_valid_o pulses.
REQ-037 CS_OFF spacing: new byte offered immediately after a last byte -> TX_ready_o SHALL stay low for 4 cycles after CS_n rises, and CS_n high time SHALL be ≥4 cycles.
REQ-038 Data stability: TX_data_i changed to 8'hFF on the cycle after acceptance of 8'h00 -> MOSI SHALL remain 0 for all 8 bits.
REQ-039 Reset mid-byte after 3 SCK pulses -> CS_n=1, SCK=0 and MOSI=0 SHALL hold during reset, with no RX_valid_o. TX_ready_o SHALL be 1 the cycle after release.
REQ-040 CLK_DIV=1 -> SCK period SHALL be 2 cycles with 50% duty, and the frame SHALL complete with a correct loopback (MISO tied to MOSI returns the sent byte).
